// File: rtl/scoreboard_hazard_unit.sv
// Scoreboard-based hazard unit for the ID stage.
// Tracks pending results from multi-cycle / variable-latency producers per
// architectural register. It detects RAW and WAW hazards against that
// scoreboard and applies redirect flushes. It also keeps a saturating stall
// counter and a sticky deadlock watchdog.
module scoreboard_hazard_unit #(
  parameter int REG_ADDR_W    = 5,
  parameter int NUM_REGS      = 2 ** REG_ADDR_W,
  parameter int LAT_W         = 4,
  parameter int CNT_W         = 32,
  parameter int STALL_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  // ID stage instruction
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic [LAT_W-1:0]      id_lat,
  // long-latency writeback
  input  logic                  wb_clear_valid,
  input  logic [REG_ADDR_W-1:0] wb_clear_rd,
  // control-flow redirect from EX
  input  logic                  redirect,
  // pipeline control
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  stall,
  // status
  output logic [NUM_REGS-1:0]   busy_mask,
  output logic [CNT_W-1:0]      stall_count,
  output logic                  deadlock_err
);

  // Latency code meaning "unknown latency": only a writeback releases it.
  localparam logic [LAT_W-1:0] LAT_INF = '1;

  // Watchdog counter is wide enough to hold STALL_TIMEOUT itself.
  localparam int              WD_W   = $clog2(STALL_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(STALL_TIMEOUT);

  // Pending bit per register, assembled from the per-entry generate blocks.
  logic [NUM_REGS-1:0] w_pending;

  // Hazard terms.
  logic w_busy_rs1;
  logic w_busy_rs2;
  logic w_busy_rd;
  logic w_raw;
  logic w_waw;
  logic w_stall;
  logic w_accept;

  // Performance counter and watchdog state.
  logic [CNT_W-1:0] r_stall_count;
  logic [WD_W-1:0]  r_wd_cnt;
  logic             r_deadlock;

  // Register 0 is hard-wired and never becomes pending.
  assign w_pending[0] = 1'b0;

  // A register is busy when pending, unless its writeback lands this very
  // cycle (the value then comes from the bypass path). x0 is never busy.
  assign w_busy_rs1 = (id_rs1 != '0) && w_pending[id_rs1] &&
                      !(wb_clear_valid && (wb_clear_rd == id_rs1));
  assign w_busy_rs2 = (id_rs2 != '0) && w_pending[id_rs2] &&
                      !(wb_clear_valid && (wb_clear_rd == id_rs2));
  assign w_busy_rd  = (id_rd  != '0) && w_pending[id_rd]  &&
                      !(wb_clear_valid && (wb_clear_rd == id_rd));

  assign w_raw = id_valid && ((id_use_rs1 && w_busy_rs1) ||
                              (id_use_rs2 && w_busy_rs2));
  assign w_waw = id_valid && id_reg_write && w_busy_rd;

  // A redirect squashes the ID instruction, so it never counts as a stall.
  assign w_stall = !redirect && (w_raw || w_waw);

  // Only instructions with a non-forwardable result that actually leave ID
  // are entered into the scoreboard.
  assign w_accept = id_valid && id_reg_write && (id_rd != '0) &&
                    (id_lat != '0) && !w_stall && !redirect;

  // Pipeline control: redirect first, then hazard stall, else free-running.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_raw || w_waw) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  assign stall = w_stall;

  // One scoreboard entry per architectural register (x0 excluded).
  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_entry
    logic             r_pend;
    logic [LAT_W-1:0] r_cnt;
    logic             w_issue_hit;
    logic             w_clear_hit;

    assign w_issue_hit = w_accept && (id_rd == REG_ADDR_W'(gi));
    assign w_clear_hit = wb_clear_valid && (wb_clear_rd == REG_ADDR_W'(gi));

    // Entry update: new issue beats writeback, writeback beats countdown.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_pend <= 1'b0;
        r_cnt  <= '0;
      end else if (w_issue_hit) begin
        r_pend <= 1'b1;
        r_cnt  <= id_lat;
      end else if (w_clear_hit) begin
        r_pend <= 1'b0;
        r_cnt  <= '0;
      end else if (r_pend && (r_cnt != LAT_INF)) begin
        if (r_cnt <= LAT_W'(1)) begin
          r_pend <= 1'b0;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt - LAT_W'(1);
        end
      end
    end

    assign w_pending[gi] = r_pend;
  end

  assign busy_mask = w_pending;

  // Saturating count of all stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign stall_count = r_stall_count;

  // Watchdog: count consecutive stalls and latch an error at the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt   <= '0;
      r_deadlock <= 1'b0;
    end else if (w_stall) begin
      if (r_wd_cnt != WD_MAX) begin
        r_wd_cnt <= r_wd_cnt + WD_W'(1);
      end
      if (r_wd_cnt >= (WD_MAX - WD_W'(1))) begin
        r_deadlock <= 1'b1;
      end
    end else begin
      r_wd_cnt <= '0;
    end
  end

  assign deadlock_err = r_deadlock;

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Bench for scoreboard_hazard_unit: per-cycle expectations are queued with
// the stimulus and compared against sampled DUT outputs at the falling edge.
module tb_scoreboard_hazard_unit;

  localparam int RW = 5;
  localparam int NR = 32;
  localparam int LW = 4;
  localparam int CW = 32;

  // Control-output encodings {stall, pc_write, if_id_write, if_id_flush, id_ex_flush}
  localparam logic [4:0] NRM = 5'b01100;
  localparam logic [4:0] STL = 5'b10001;
  localparam logic [4:0] RDR = 5'b01111;

  logic          clk;
  logic          rst;
  logic          id_valid;
  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic          id_use_rs1;
  logic          id_use_rs2;
  logic [RW-1:0] id_rd;
  logic          id_reg_write;
  logic [LW-1:0] id_lat;
  logic          wb_clear_valid;
  logic [RW-1:0] wb_clear_rd;
  logic          redirect;
  logic          pc_write;
  logic          if_id_write;
  logic          if_id_flush;
  logic          id_ex_flush;
  logic          stall;
  logic [NR-1:0] busy_mask;
  logic [CW-1:0] stall_count;
  logic          deadlock_err;

  typedef struct packed {
    logic [4:0]    ctl;
    logic [NR-1:0] busy;
    logic [CW-1:0] cnt;
    logic          dead;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  scoreboard_hazard_unit #(
    .REG_ADDR_W   (RW),
    .NUM_REGS     (NR),
    .LAT_W        (LW),
    .CNT_W        (CW),
    .STALL_TIMEOUT(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .id_rd         (id_rd),
    .id_reg_write  (id_reg_write),
    .id_lat        (id_lat),
    .wb_clear_valid(wb_clear_valid),
    .wb_clear_rd   (wb_clear_rd),
    .redirect      (redirect),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .stall         (stall),
    .busy_mask     (busy_mask),
    .stall_count   (stall_count),
    .deadlock_err  (deadlock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t sample_outputs();
    obs_t o;
    o.ctl  = {stall, pc_write, if_id_write, if_id_flush, id_ex_flush};
    o.busy = busy_mask;
    o.cnt  = stall_count;
    o.dead = deadlock_err;
    return o;
  endfunction

  task automatic push_exp(input logic [4:0] ctl, input logic [NR-1:0] busy,
                          input logic [CW-1:0] cnt, input logic dead);
    obs_t e;
    e.ctl  = ctl;
    e.busy = busy;
    e.cnt  = cnt;
    e.dead = dead;
    exp_q.push_back(e);
  endtask

  task automatic set_idle();
    id_valid       = 1'b0;
    id_rs1         = '0;
    id_rs2         = '0;
    id_use_rs1     = 1'b0;
    id_use_rs2     = 1'b0;
    id_rd          = '0;
    id_reg_write   = 1'b0;
    id_lat         = '0;
    wb_clear_valid = 1'b0;
    wb_clear_rd    = '0;
    redirect       = 1'b0;
  endtask

  task automatic set_id(input logic [RW-1:0] rs1, input logic use1,
                        input logic [RW-1:0] rs2, input logic use2,
                        input logic [RW-1:0] rd, input logic rw,
                        input logic [LW-1:0] lat);
    id_valid     = 1'b1;
    id_rs1       = rs1;
    id_use_rs1   = use1;
    id_rs2       = rs2;
    id_use_rs2   = use2;
    id_rd        = rd;
    id_reg_write = rw;
    id_lat       = lat;
  endtask

  task automatic set_wb(input logic [RW-1:0] rd);
    wb_clear_valid = 1'b1;
    wb_clear_rd    = rd;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      set_idle();
      push_exp(NRM, '0, '0, 1'b0);
      @(negedge clk);
      got = sample_outputs();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL reset c%0d got ctl=%b busy=%h cnt=%0d dl=%b exp ctl=%b busy=%h cnt=%0d dl=%b",
                 c, got.ctl, got.busy, got.cnt, got.dead, exp.ctl, exp.busy, exp.cnt, exp.dead);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_load_use();
    obs_t got, exp;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_idle();
      case (c)
        0: begin set_id(0, 0, 0, 0, 5, 1, 1); push_exp(NRM, '0, 0, 0); end
        1: begin set_id(5, 1, 0, 0, 0, 0, 0); push_exp(STL, 32'd1 << 5, 0, 0); end
        2: begin set_id(5, 1, 0, 0, 0, 0, 0); push_exp(NRM, '0, 1, 0); end
        default: push_exp(NRM, '0, 1, 0);
      endcase
      @(negedge clk);
      got = sample_outputs();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL load_use c%0d got ctl=%b busy=%h cnt=%0d dl=%b exp ctl=%b busy=%h cnt=%0d dl=%b",
                 c, got.ctl, got.busy, got.cnt, got.dead, exp.ctl, exp.busy, exp.cnt, exp.dead);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mul();
    obs_t got, exp;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      set_idle();
      case (c)
        0: begin set_id(0, 0, 0, 0, 7, 1, 3); push_exp(NRM, '0, 0, 0); end
        1, 2, 3: begin
          set_id(0, 0, 7, 1, 0, 0, 0);
          push_exp(STL, 32'd1 << 7, CW'(c - 1), 0);
        end
        // consumer finally issues; it writes x8 with a forwardable result
        4: begin set_id(0, 0, 7, 1, 8, 1, 0); push_exp(NRM, '0, 3, 0); end
        default: push_exp(NRM, '0, 3, 0);
      endcase
      @(negedge clk);
      got = sample_outputs();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL mul c%0d got ctl=%b busy=%h cnt=%0d dl=%b exp ctl=%b busy=%h cnt=%0d dl=%b",
                 c, got.ctl, got.busy, got.cnt, got.dead, exp.ctl, exp.busy, exp.cnt, exp.dead);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_lat_inf();
    obs_t got, exp;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      set_idle();
      if (c == 0) begin
        set_id(0, 0, 0, 0, 9, 1, 4'hF);
        push_exp(NRM, '0, 0, 1'b0);
      end else if (c <= 9) begin
        set_id(9, 1, 0, 0, 0, 0, 0);
        push_exp(STL, 32'd1 << 9, CW'(c - 1), 1'b1 & (c >= 5));
      end else if (c == 10) begin
        set_id(9, 1, 0, 0, 0, 0, 0);
        set_wb(9);
        push_exp(NRM, 32'd1 << 9, 9, 1'b1);
      end else begin
        push_exp(NRM, '0, 9, 1'b1);
      end
      @(negedge clk);
      got = sample_outputs();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL lat_inf c%0d got ctl=%b busy=%h cnt=%0d dl=%b exp ctl=%b busy=%h cnt=%0d dl=%b",
                 c, got.ctl, got.busy, got.cnt, got.dead, exp.ctl, exp.busy, exp.cnt, exp.dead);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_redirect_waw();
    obs_t got, exp;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      set_idle();
      case (c)
        0: begin set_id(0, 0, 0, 0, 4, 1, 3); push_exp(NRM, '0, 0, 0); end
        1: begin set_id(4, 1, 0, 0, 0, 0, 0); push_exp(STL, 32'd1 << 4, 0, 0); end
        // redirect during the RAW stall; the lat=2 write to x10 must be dropped
        2: begin
          set_id(4, 1, 0, 0, 10, 1, 2);
          redirect = 1'b1;
          push_exp(RDR, 32'd1 << 4, 1, 0);
        end
        // WAW: rewrite x4 while its long result is still pending
        3: begin set_id(0, 0, 0, 0, 4, 1, 0); push_exp(STL, 32'd1 << 4, 1, 0); end
        default: begin set_id(0, 0, 0, 0, 4, 1, 0); push_exp(NRM, '0, 2, 0); end
      endcase
      @(negedge clk);
      got = sample_outputs();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL redirect_waw c%0d got ctl=%b busy=%h cnt=%0d dl=%b exp ctl=%b busy=%h cnt=%0d dl=%b",
                 c, got.ctl, got.busy, got.cnt, got.dead, exp.ctl, exp.busy, exp.cnt, exp.dead);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_boundary();
    obs_t got, exp;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      set_idle();
      case (c)
        // x0 is never tracked, and a writeback to x0 is ignored
        0: begin set_id(0, 0, 0, 0, 0, 1, 3); set_wb(0); push_exp(NRM, '0, 0, 0); end
        // read x0 (never busy); issue x6 with a same-cycle writeback to x6
        1: begin set_id(0, 1, 0, 1, 6, 1, 4'hF); set_wb(6); push_exp(NRM, '0, 0, 0); end
        2: push_exp(NRM, 32'd1 << 6, 0, 0);
        3: begin set_wb(6); push_exp(NRM, 32'd1 << 6, 0, 0); end
        default: push_exp(NRM, '0, 0, 0);
      endcase
      @(negedge clk);
      got = sample_outputs();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL boundary c%0d got ctl=%b busy=%h cnt=%0d dl=%b exp ctl=%b busy=%h cnt=%0d dl=%b",
                 c, got.ctl, got.busy, got.cnt, got.dead, exp.ctl, exp.busy, exp.cnt, exp.dead);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_deadlock();
    obs_t got, exp;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      set_idle();
      if (c == 0) begin
        set_id(0, 0, 0, 0, 3, 1, 4'hF);
        push_exp(NRM, '0, 0, 1'b0);
      end else if (c <= 7) begin
        set_id(3, 1, 0, 0, 0, 0, 0);
        push_exp(STL, 32'd1 << 3, CW'(c - 1), (c >= 5));
      end else if (c == 8) begin
        push_exp(NRM, 32'd1 << 3, 7, 1'b1);
      end else if (c == 9) begin
        rst = 1'b1;
        set_wb(3);
        push_exp(NRM, 32'd1 << 3, 7, 1'b1);
      end else begin
        rst = 1'b0;
        push_exp(NRM, '0, 0, 1'b0);
      end
      @(negedge clk);
      got = sample_outputs();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL deadlock c%0d got ctl=%b busy=%h cnt=%0d dl=%b exp ctl=%b busy=%h cnt=%0d dl=%b",
                 c, got.ctl, got.busy, got.cnt, got.dead, exp.ctl, exp.busy, exp.cnt, exp.dead);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_load_use();
    test_mul();
    test_lat_inf();
    test_redirect_waw();
    test_boundary();
    test_deadlock();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
